// File: rtl/axis_buf_pkg.sv
// Shared defaults, entry field layout and helpers for the AXI-S elastic buffer.
// Each stored entry is packed as {tlast, tuser, tdata}.
package axis_buf_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_USER_W = 22;
    localparam int DEF_DEPTH  = 512;
    localparam int DEF_MARGIN = 64;

    localparam int TDATA_LSB = 0;

    function automatic int tuser_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int tlast_bit(input int data_w, input int user_w);
        return data_w + user_w;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// The read register only updates on i_re so it can hold a beat while stalled.
module sdp_ram
    import axis_buf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: RAM, read-data stage and output register,
// with advisory ready, overflow tracking and optional store-and-forward.
module axis_elastic_buffer
    import axis_buf_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int USER_W       = DEF_USER_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int MARGIN       = DEF_MARGIN,
    parameter int ADVISORY_RDY = 1,
    parameter int PKT_MODE     = 0,
    localparam int LW          = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_rx_tdata,
    input  logic [USER_W-1:0] s_axis_rx_tuser,
    input  logic              s_axis_rx_tlast,
    input  logic              s_axis_rx_tvalid,
    output logic              s_axis_rx_tready,
    output logic [DATA_W-1:0] m_axis_rx_tdata,
    output logic [USER_W-1:0] m_axis_rx_tuser,
    output logic              m_axis_rx_tlast,
    output logic              m_axis_rx_tvalid,
    input  logic              m_axis_rx_tready,
    output logic [LW-1:0]     level,
    output logic              ovf
);

    localparam int AW       = clog2(DEPTH);
    localparam int EW       = DATA_W + USER_W + 1;
    localparam int USER_LSB = tuser_lsb(DATA_W);
    localparam int LAST_BIT = tlast_bit(DATA_W, USER_W);

    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] L_THR  = LW'(DEPTH - MARGIN);
    localparam logic [LW-1:0] P_ONE  = LW'(1);
    localparam logic          C_ADV  = (ADVISORY_RDY != 0);
    localparam logic          C_PKT  = (PKT_MODE != 0);

    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   r_pkt_cnt;
    logic            r_rdy;
    logic            r_ovf;
    logic            r_cut;
    logic            r_s1_vld;
    logic            r_m_vld;
    logic [EW-1:0]   r_m_data;
    logic            r_last_q [DEPTH];

    logic [EW-1:0]   w_din;
    logic [EW-1:0]   w_dout;
    logic [AW:0]     w_ram_cnt;
    logic            w_take;
    logic            w_try;
    logic            w_room;
    logic            w_wr;
    logic            w_drop;
    logic            w_s2_free;
    logic            w_s1_mv;
    logic            w_s1_free;
    logic            w_rd_ok;
    logic            w_re;
    logic            w_rd_last;
    logic            w_full;
    logic            w_pkt_inc;
    logic            w_pkt_dec;

    always_comb begin
        w_din = '0;
        w_din[TDATA_LSB +: DATA_W] = s_axis_rx_tdata;
        w_din[USER_LSB +: USER_W]  = s_axis_rx_tuser;
        w_din[LAST_BIT]            = s_axis_rx_tlast;
    end

    // A departing beat frees its slot in the same cycle, so full accepts too
    assign w_take    = r_m_vld & m_axis_rx_tready;
    assign w_try     = s_axis_rx_tvalid & (r_rdy | C_ADV);
    assign w_room    = (r_level != L_FULL) | w_take;
    assign w_wr      = w_try & w_room;
    assign w_drop    = w_try & ~w_room;

    assign w_ram_cnt = r_wptr - r_rptr;
    assign w_s2_free = ~r_m_vld | m_axis_rx_tready;
    assign w_s1_mv   = r_s1_vld & w_s2_free;
    assign w_s1_free = ~r_s1_vld | w_s2_free;
    assign w_rd_last = r_last_q[r_rptr[AW-1:0]];

    // Strict mode never reaches DEPTH; blocked upstream counts as full there
    assign w_full    = (r_level == L_FULL) | (~C_ADV & (r_level > L_THR));
    assign w_rd_ok   = ~C_PKT | (r_pkt_cnt != '0) | r_cut;
    assign w_re      = (w_ram_cnt != '0) & w_s1_free & w_rd_ok;

    assign w_pkt_inc = w_wr & s_axis_rx_tlast;
    assign w_pkt_dec = w_re & w_rd_last;

    sdp_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (w_din),
        .i_re    (w_re),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_pkt_cnt <= '0;
            r_rdy     <= 1'b0;
            r_ovf     <= 1'b0;
            r_cut     <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_m_vld   <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + P_ONE;
            if (w_re) r_rptr <= r_rptr + P_ONE;
            if (w_wr != w_take)
                r_level <= w_wr ? r_level + P_ONE : r_level - P_ONE;
            if (w_pkt_inc != w_pkt_dec)
                r_pkt_cnt <= w_pkt_inc ? r_pkt_cnt + P_ONE
                                       : r_pkt_cnt - P_ONE;
            r_rdy <= (r_level <= L_THR);
            if (w_drop) r_ovf <= 1'b1;
            if (w_pkt_dec)
                r_cut <= 1'b0;
            else if (C_PKT && w_full && r_pkt_cnt == '0)
                r_cut <= 1'b1;
            r_s1_vld <= w_re | (r_s1_vld & ~w_s1_mv);
            if (w_s1_mv)
                r_m_vld <= 1'b1;
            else if (w_take)
                r_m_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_mv) r_m_data <= w_dout;
        if (w_wr) r_last_q[r_wptr[AW-1:0]] <= s_axis_rx_tlast;
    end

    assign s_axis_rx_tready = r_rdy;
    assign m_axis_rx_tvalid = r_m_vld;
    assign m_axis_rx_tdata  = r_m_data[TDATA_LSB +: DATA_W];
    assign m_axis_rx_tuser  = r_m_data[USER_LSB +: USER_W];
    assign m_axis_rx_tlast  = r_m_data[LAST_BIT];
    assign level            = r_level;
    assign ovf              = r_ovf;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Directed bench for axis_elastic_buffer: three instances cover cut-through,
// store-and-forward with advisory ready, and store-and-forward strict AXI-S.
module tb_axis_elastic_buffer;

    localparam int DW = 16;
    localparam int UW = 4;
    localparam int D  = 16;
    localparam int LW = 5;
    localparam int EW = DW + UW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] s_dat  [3];
    logic [UW-1:0] s_usr  [3];
    logic          s_last [3];
    logic          s_vld  [3];
    logic          s_rdy  [3];
    logic [DW-1:0] m_dat  [3];
    logic [UW-1:0] m_usr  [3];
    logic          m_last [3];
    logic          m_vld  [3];
    logic          m_rdy  [3];
    logic [LW-1:0] lvl    [3];
    logic          ovf    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_elastic_buffer #(
            .DATA_W       (DW),
            .USER_W       (UW),
            .DEPTH        (D),
            .MARGIN       (4),
            .ADVISORY_RDY ((g == 2) ? 0 : 1),
            .PKT_MODE     ((g == 0) ? 0 : 1)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .s_axis_rx_tdata  (s_dat[g]),
            .s_axis_rx_tuser  (s_usr[g]),
            .s_axis_rx_tlast  (s_last[g]),
            .s_axis_rx_tvalid (s_vld[g]),
            .s_axis_rx_tready (s_rdy[g]),
            .m_axis_rx_tdata  (m_dat[g]),
            .m_axis_rx_tuser  (m_usr[g]),
            .m_axis_rx_tlast  (m_last[g]),
            .m_axis_rx_tvalid (m_vld[g]),
            .m_axis_rx_tready (m_rdy[g]),
            .level            (lvl[g]),
            .ovf              (ovf[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int sel = 0;
    int rx_cnt = 0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ex(input int v, input bit last);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        d = DW'(v);
        u = UW'(v);
        return 32'({last, u, d});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit last);
        s_dat[sel]  = DW'(v);
        s_usr[sel]  = UW'(v);
        s_last[sel] = last;
        s_vld[sel]  = 1'b1;
        tick();
        s_vld[sel]  = 1'b0;
    endtask

    // Scoreboard: a handshake seen at negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_vld[sel] === 1'b1 && m_rdy[sel] === 1'b1) begin
            rx_cnt++;
            chk("rx_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0)
                chk("rx_beat", 32'({m_last[sel], m_usr[sel], m_dat[sel]}),
                    q.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int early;
        int i;
        int rx_at_last;
        bit acc;

        for (int k = 0; k < 3; k++) begin
            s_vld[k] = 1'b0; s_last[k] = 1'b0;
            s_dat[k] = '0;   s_usr[k] = '0;
            m_rdy[k] = 1'b0;
        end
        rst_n = 1'b0;
        sel = 0;
        tick();
        tick();
        chk("rst_mvalid", 32'(m_vld[0]), 32'd0);
        chk("rst_level", 32'(lvl[0]), 32'd0);
        chk("rst_ovf", 32'(ovf[0]), 32'd0);
        chk("rst_tready", 32'(s_rdy[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("tready_after_rst", 32'(s_rdy[0]), 32'd1);

        m_rdy[0] = 1'b1;
        q.push_back(ex(32'hA5, 1'b1));
        send(32'hA5, 1'b1);
        chk("single_level1", 32'(lvl[0]), 32'd1);
        chk("single_wr0", 32'(m_vld[0]), 32'd0);
        tick();
        chk("single_wr1", 32'(m_vld[0]), 32'd0);
        tick();
        chk("single_wr2_valid", 32'(m_vld[0]), 32'd1);
        chk("single_data", 32'(m_dat[0]), 32'h00A5);
        tick();
        chk("single_level0", 32'(lvl[0]), 32'd0);
        chk("single_rx", 32'(rx_cnt), 32'd1);

        m_rdy[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 16) q.push_back(ex(k, (k % 5) == 0));
            send(k, (k % 5) == 0);
            if (k == 13) chk("tready_hi_13", 32'(s_rdy[0]), 32'd1);
            if (k == 14) chk("tready_lo_14", 32'(s_rdy[0]), 32'd0);
        end
        chk("ovf_level", 32'(lvl[0]), 32'd16);
        chk("ovf_flag", 32'(ovf[0]), 32'd1);
        chk("ovf_head_valid", 32'(m_vld[0]), 32'd1);
        tick(); tick(); tick();
        chk("stall_hold_valid", 32'(m_vld[0]), 32'd1);
        chk("stall_hold_data", 32'(m_dat[0]), 32'd1);

        m_rdy[0] = 1'b1;
        for (int k = 21; k <= 120; k++) begin
            q.push_back(ex(k, (k % 5) == 0));
            send(k, (k % 5) == 0);
            chk("full_level", 32'(lvl[0]), 32'd16);
        end
        chk("full_rate", 32'(rx_cnt), 32'd101);
        for (int k = 0; k < 100 && q.size() != 0; k++) tick();
        tick();
        tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_level", 32'(lvl[0]), 32'd0);
        chk("drain_rx", 32'(rx_cnt), 32'd117);

        m_rdy[0] = 1'b0;
        for (int k = 1; k <= 7; k++) send(200 + k, 1'b0);
        tick();
        chk("prerst_level", 32'(lvl[0]), 32'd7);
        chk("prerst_valid", 32'(m_vld[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(m_vld[0]), 32'd0);
        chk("midrst_level", 32'(lvl[0]), 32'd0);
        chk("midrst_ovf", 32'(ovf[0]), 32'd0);
        chk("midrst_tready", 32'(s_rdy[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_tready_rel", 32'(s_rdy[0]), 32'd1);
        m_rdy[0] = 1'b1;
        repeat (6) tick();
        chk("midrst_flushed", 32'(rx_cnt), 32'd117);

        rst_n = 1'b0;
        sel = 1;
        tick();
        rst_n = 1'b1;
        tick();
        m_rdy[1] = 1'b1;
        base = rx_cnt;
        early = 0;
        for (int k = 1; k <= 4; k++) begin
            q.push_back(ex(300 + k, 1'b0));
            send(300 + k, 1'b0);
            if (m_vld[1] !== 1'b0) early++;
        end
        repeat (10) begin
            tick();
            if (m_vld[1] !== 1'b0) early++;
        end
        chk("pkt_hold_early", 32'(early), 32'd0);
        q.push_back(ex(305, 1'b1));
        send(305, 1'b1);
        chk("pkt_wr0", 32'(m_vld[1]), 32'd0);
        tick();
        chk("pkt_wr1", 32'(m_vld[1]), 32'd0);
        tick();
        chk("pkt_wr2_valid", 32'(m_vld[1]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pkt_back2back", 32'(m_vld[1]), 32'd1);
        end
        tick();
        chk("pkt_end_valid", 32'(m_vld[1]), 32'd0);
        chk("pkt_rx", 32'(rx_cnt - base), 32'd5);

        rst_n = 1'b0;
        sel = 2;
        tick();
        rst_n = 1'b1;
        tick();
        m_rdy[2] = 1'b1;
        base = rx_cnt;
        rx_at_last = 0;
        i = 1;
        for (int k = 0; k < 300 && i <= 20; k++) begin
            s_dat[2]  = DW'(i);
            s_usr[2]  = UW'(i);
            s_last[2] = (i == 20);
            s_vld[2]  = 1'b1;
            acc = s_rdy[2];
            if (acc) q.push_back(ex(i, i == 20));
            if (acc && i == 20) rx_at_last = rx_cnt - base;
            tick();
            if (acc) i++;
        end
        s_vld[2] = 1'b0;
        chk("cut_all_sent", 32'(i), 32'd21);
        for (int k = 0; k < 200 && q.size() != 0; k++) tick();
        tick();
        tick();
        chk("cut_drain_empty", 32'(q.size()), 32'd0);
        chk("cut_rx", 32'(rx_cnt - base), 32'd20);
        chk("cut_released_early", 32'(rx_at_last > 0), 32'd1);
        chk("cut_ovf", 32'(ovf[2]), 32'd0);
        chk("cut_level", 32'(lvl[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_elastic_buffer.md
AXIS_ELASTIC_BUFFER -- requirements
Module: axis_elastic_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 128, tdata width in bits.
REQ-002 SHALL have parameter USER_W, default 22, tuser width in bits; passed through unmodified.
REQ-003 SHALL have parameter DEPTH, default 512, entry count; power of two, 16..4096.
REQ-004 SHALL have parameter MARGIN, default 64, free entries kept in reserve when s_tready drops; 4..DEPTH/2.
REQ-005 SHALL have parameter ADVISORY_RDY, default 1; 1 = beats are written on s_tvalid alone, ready is a hint only; 0 = strict AXI-S.
REQ-006 SHALL have parameter PKT_MODE, default 0; 0 = cut-through, 1 = store-and-forward.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have ports s_axis_rx_tdata/tuser/tlast/tvalid, input, DATA_W/USER_W/1/1, upstream beat.
REQ-010 SHALL have port s_axis_rx_tready, output, 1, registered, upstream ready.
REQ-011 SHALL have ports m_axis_rx_tdata/tuser/tlast/tvalid, output, DATA_W/USER_W/1/1, downstream beat.
REQ-012 SHALL have port m_axis_rx_tready, input, 1, downstream ready.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1, current occupancy including the output register.
REQ-014 SHALL have port ovf, output, 1, sticky flag; set when a beat is dropped.

Function
REQ-015 SHALL write a beat when wr = s_tvalid & (s_tready | ADVISORY_RDY) & (level_w < DEPTH); level_w counts RAM entries plus the output register.
REQ-016 SHALL discard the beat and set ovf when s_tvalid & (s_tready | ADVISORY_RDY) & (level_w == DEPTH); ovf clears only on reset.
REQ-017 SHALL register s_tready as (level_w + MARGIN <= DEPTH), evaluated on the cycle before it is driven.
REQ-018 SHALL store {tlast, tuser, tdata} per entry, with write/read pointers wrapping modulo DEPTH.
REQ-019 SHALL present the first beat into an empty buffer on m_tvalid exactly 2 cycles after the write edge (RAM read, then output register); PKT_MODE=0.
REQ-020 SHALL hold m_tdata/tuser/tlast stable while m_tvalid & ~m_tready, and never deassert m_tvalid without a handshake.
REQ-021 SHALL sustain one beat per cycle in both directions when neither side stalls; the prefetch path has no bubbles.
REQ-022 SHALL, on a simultaneous write and read, leave level unchanged; this includes the full and one-entry cases.
REQ-023 SHALL, in PKT_MODE=1, keep a packet count that increments on a tlast write and decrements on a tlast read handshake, and issue RAM reads only while the count is nonzero or a packet is mid-egress.
REQ-024 SHALL, in PKT_MODE=1, when level_w == DEPTH with a packet count of 0, release data cut-through until the next tlast leaves, to prevent deadlock.
REQ-025 SHALL drive level combinationally from registered counters; level never exceeds DEPTH.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, clear pointers, level, packet count and ovf to 0, and drive m_tvalid=0 and s_tready=0.
REQ-027 SHALL drive s_tready=1 on the first cycle after rst_n returns to 1.
REQ-028 SHALL discard all stored and in-flight beats on a mid-operation reset; no beat predating reset reaches m_axis.
REQ-029 SHALL leave RAM contents unreset; m_tdata is don't-care while m_tvalid=0.

Structure
REQ-030 SHALL place default widths, the entry field offsets (tlast/tuser/tdata) and the clog2 function in shared package axis_buf_pkg.
REQ-031 SHALL instantiate one sub-module, sdp_ram (simple dual-port, registered read, width DATA_W+USER_W+1, depth DEPTH); control logic stays in axis_elastic_buffer.

Verification
REQ-032 SHALL cover: empty buffer, single beat 0xA5 with tlast, m_tready=1 -> m_tvalid at write+2, data 0xA5, level returns to 0.
REQ-033 SHALL cover: DEPTH=16, MARGIN=4, m_tready=0, 20 continuous beats with ADVISORY_RDY=1 -> s_tready drops after level 12, beats 1..16 stored, 17..20 dropped, ovf=1, level=16.
REQ-034 SHALL cover: full buffer, m_tready=1 with continuous writes for 100 cycles -> level stays 16, output is the in-order counting pattern, no gaps.
REQ-035 SHALL cover: PKT_MODE=1, 5-beat packet with a 10-cycle gap before tlast -> m_tvalid stays 0 until 2 cycles after the tlast write, then 5 back-to-back beats.
REQ-036 SHALL cover: PKT_MODE=1, DEPTH=16, 20-beat packet, no tlast until beat 20 -> cut-through release at full, all 20 beats delivered in order, ovf=0 with ADVISORY_RDY=0.
REQ-037 SHALL cover: rst_n=0 for 1 cycle with level=7 and m_tvalid=1 -> next cycle m_tvalid=0, level=0, ovf=0, s_tready=1 one cycle after release.
